// File: rtl/lsu_axil_bridge.sv
// lsu_axil_bridge: converts each core data request into a single
// AXI4-Lite transaction and returns a one-cycle completion pulse.
module lsu_axil_bridge #(
   parameter int XLEN       = 32,
   parameter bit ALIGN_ADDR = 1'b1
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            core_valid,
   input  logic            core_wen,
   input  logic [XLEN-1:0] core_addr,
   input  logic [3:0]      core_wstrb,
   input  logic [XLEN-1:0] core_wdata,
   output logic            core_done,
   output logic [XLEN-1:0] core_rdata,
   output logic            core_err,
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [XLEN-1:0] m_awaddr,
   output logic            m_wvalid,
   input  logic            m_wready,
   output logic [XLEN-1:0] m_wdata,
   output logic [3:0]      m_wstrb,
   input  logic            m_bvalid,
   output logic            m_bready,
   input  logic [1:0]      m_bresp,
   output logic            m_arvalid,
   input  logic            m_arready,
   output logic [XLEN-1:0] m_araddr,
   input  logic            m_rvalid,
   output logic            m_rready,
   input  logic [XLEN-1:0] m_rdata,
   input  logic [1:0]      m_rresp
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
   } state_t;

   state_t          state;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      wstrb_q;
   logic            aw_sent;
   logic            w_sent;
   logic            aw_fire;
   logic            w_fire;
   logic            aw_ok;
   logic            w_ok;
   logic [XLEN-1:0] bus_addr;

   assign bus_addr = ALIGN_ADDR ? {addr_q[XLEN-1:2], 2'b00}
                                : addr_q;
   assign m_awaddr = bus_addr;
   assign m_araddr = bus_addr;
   assign m_wdata  = wdata_q;
   assign m_wstrb  = wstrb_q;

   // AW and W complete independently; a beat counts as sent
   // either from an earlier cycle or from this cycle's handshake.
   assign aw_fire = m_awvalid & m_awready;
   assign w_fire  = m_wvalid & m_wready;
   assign aw_ok   = aw_sent | aw_fire;
   assign w_ok    = w_sent | w_fire;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_sent    <= 1'b0;
         w_sent     <= 1'b0;
         m_awvalid  <= 1'b0;
         m_wvalid   <= 1'b0;
         m_bready   <= 1'b0;
         m_arvalid  <= 1'b0;
         m_rready   <= 1'b0;
         core_done  <= 1'b0;
         core_err   <= 1'b0;
         core_rdata <= '0;
      end else begin
         core_done <= 1'b0;
         core_err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (core_valid) begin
                  addr_q  <= core_addr;
                  wdata_q <= core_wdata;
                  wstrb_q <= core_wstrb;
                  if (core_wen) begin
                     state     <= WR_REQ;
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     aw_sent   <= 1'b0;
                     w_sent    <= 1'b0;
                  end else begin
                     state     <= RD_ADDR;
                     m_arvalid <= 1'b1;
                  end
               end
            end
            RD_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_rvalid) begin
                  core_rdata <= m_rdata;
                  m_rready   <= 1'b0;
                  core_done  <= 1'b1;
                  core_err   <= |m_rresp;
                  state      <= DONE;
               end
            end
            WR_REQ: begin
               if (aw_fire) begin
                  m_awvalid <= 1'b0;
                  aw_sent   <= 1'b1;
               end
               if (w_fire) begin
                  m_wvalid <= 1'b0;
                  w_sent   <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  m_bready <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_bvalid) begin
                  m_bready  <= 1'b0;
                  core_done <= 1'b1;
                  core_err  <= |m_bresp;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axil_bridge.sv
// tb_lsu_axil_bridge: scripted and randomized AXI4-Lite slave
// scenarios checked against a cycle-count/value reference model.
module tb_lsu_axil_bridge;

   logic        clk;
   logic        rst_b;
   logic        core_valid;
   logic        core_wen;
   logic [31:0] core_addr;
   logic [3:0]  core_wstrb;
   logic [31:0] core_wdata;
   logic        core_done;
   logic [31:0] core_rdata;
   logic        core_err;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_awaddr;
   logic        m_wvalid;
   logic        m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid;
   logic        m_bready;
   logic [1:0]  m_bresp;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_araddr;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   int pass_cnt;
   int total_cnt;

   int          o_done_cyc, o_done_cnt;
   int          o_ar_hs, o_r_hs, o_aw_hs, o_w_hs, o_b_hs;
   int          o_ar_cyc, o_aw_cyc, o_w_cyc;
   logic        o_err;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_wstrb;
   bit          o_late, o_unstable, o_bad;
   logic [31:0] rd_model;

   lsu_axil_bridge #(.XLEN(32), .ALIGN_ADDR(1'b1)) dut (
      .clk(clk), .rst_b(rst_b),
      .core_valid(core_valid), .core_wen(core_wen),
      .core_addr(core_addr), .core_wstrb(core_wstrb),
      .core_wdata(core_wdata), .core_done(core_done),
      .core_rdata(core_rdata), .core_err(core_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_awaddr(m_awaddr), .m_wvalid(m_wvalid),
      .m_wready(m_wready), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_bvalid(m_bvalid),
      .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_araddr(m_araddr), .m_rvalid(m_rvalid),
      .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave waits count cycles of visible valid (AR/AW/W) or of
   // the response phase (R/B). Cycle 0 is the negedge of request.
   task automatic run_txn(
      input bit wen, input logic [31:0] addr,
      input logic [31:0] wd, input logic [3:0] st,
      input int aw_w, input int w_w, input int ar_w,
      input int r_w, input int b_w, input logic [1:0] resp,
      input logic [31:0] rd, input int tail);
      int cyc, rc, bc;
      bit aw_ok, w_ok, ar_ok, r_ok, b_ok, ebr, err;
      logic [31:0] a_first, aw_first, w_first;
      logic [3:0]  s_first;
      o_done_cyc = -1; o_done_cnt = 0;
      o_ar_hs = 0; o_r_hs = 0; o_aw_hs = 0; o_w_hs = 0; o_b_hs = 0;
      o_ar_cyc = 0; o_aw_cyc = 0; o_w_cyc = 0;
      o_err = 1'b0; o_rdata = '0; o_addr = '0;
      o_wdata = '0; o_wstrb = '0;
      o_late = 0; o_unstable = 0; o_bad = 0;
      aw_ok = 0; w_ok = 0; ar_ok = 0; r_ok = 0; b_ok = 0;
      a_first = '0; aw_first = '0; w_first = '0; s_first = '0;
      cyc = 0; rc = 0; bc = 0;
      core_valid = 1'b1; core_wen = wen; core_addr = addr;
      core_wdata = wd; core_wstrb = st;
      while (o_done_cnt == 0 && cyc < 100) begin
         @(posedge clk); @(negedge clk); cyc++;
         ebr = wen && aw_ok && w_ok && !b_ok;
         err = !wen && ar_ok && !r_ok;
         if (m_bready !== ebr || m_rready !== err) o_bad = 1;
         if (core_done === 1'b1) begin
            o_done_cnt++; o_done_cyc = cyc;
            o_err = core_err; o_rdata = core_rdata;
            core_valid = 1'b0;
         end
         m_rvalid = 0; m_bvalid = 0;
         m_arready = 0; m_awready = 0; m_wready = 0;
         if (ar_ok && !r_ok) begin
            if (rc >= r_w) begin
               m_rvalid = 1; m_rdata = rd; m_rresp = resp;
               if (m_rready) begin r_ok = 1; o_r_hs++; end
            end
            rc++;
         end
         if (aw_ok && w_ok && !b_ok) begin
            if (bc >= b_w) begin
               m_bvalid = 1; m_bresp = resp;
               if (m_bready) begin b_ok = 1; o_b_hs++; end
            end
            bc++;
         end
         if (m_arvalid === 1'b1) begin
            if (ar_ok) o_late = 1;
            else begin
               if (o_ar_cyc == 0) a_first = m_araddr;
               else if (m_araddr !== a_first) o_unstable = 1;
               if (o_ar_cyc >= ar_w) begin
                  m_arready = 1; ar_ok = 1; o_ar_hs++;
                  o_addr = m_araddr;
               end
               o_ar_cyc++;
            end
         end
         if (m_awvalid === 1'b1) begin
            if (aw_ok) o_late = 1;
            else begin
               if (o_aw_cyc == 0) aw_first = m_awaddr;
               else if (m_awaddr !== aw_first) o_unstable = 1;
               if (o_aw_cyc >= aw_w) begin
                  m_awready = 1; aw_ok = 1; o_aw_hs++;
                  o_addr = m_awaddr;
               end
               o_aw_cyc++;
            end
         end
         if (m_wvalid === 1'b1) begin
            if (w_ok) o_late = 1;
            else begin
               if (o_w_cyc == 0) begin
                  w_first = m_wdata; s_first = m_wstrb;
               end else if (m_wdata !== w_first ||
                            m_wstrb !== s_first) o_unstable = 1;
               if (o_w_cyc >= w_w) begin
                  m_wready = 1; w_ok = 1; o_w_hs++;
                  o_wdata = m_wdata; o_wstrb = m_wstrb;
               end
               o_w_cyc++;
            end
         end
      end
      core_valid = 1'b0;
      m_rvalid = 0; m_bvalid = 0;
      m_arready = 0; m_awready = 0; m_wready = 0;
      for (int k = 0; k < tail; k++) begin
         @(posedge clk); @(negedge clk);
         if (core_done === 1'b1) o_done_cnt++;
         if (m_arvalid || m_awvalid || m_wvalid) o_late = 1;
      end
   endtask

   task automatic test_reset;
      total_cnt++;
      if ({m_arvalid, m_awvalid, m_wvalid} !== 3'b000)
         $display("FAIL rst_valids got %b want 000",
                  {m_arvalid, m_awvalid, m_wvalid});
      else pass_cnt++;
      total_cnt++;
      if ({m_rready, m_bready, core_done, core_err} !== 4'b0)
         $display("FAIL rst_ready_done got %b want 0000",
                  {m_rready, m_bready, core_done, core_err});
      else pass_cnt++;
      total_cnt++;
      if (core_rdata !== 32'h0)
         $display("FAIL rst_rdata got %h want 0", core_rdata);
      else pass_cnt++;
      total_cnt++;
      if ({m_araddr, m_awaddr, m_wdata, m_wstrb} !== 100'h0)
         $display("FAIL rst_regs got %h %h %h %h want 0",
                  m_araddr, m_awaddr, m_wdata, m_wstrb);
      else pass_cnt++;
   endtask

   task automatic test_read_zero;
      run_txn(0, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0,
              2'b00, 32'hDEAD_BEEF, 3);
      rd_model = 32'hDEAD_BEEF;
      total_cnt++;
      if (o_done_cyc !== 3)
         $display("FAIL rd0_latency got %0d want 3", o_done_cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_done_cnt !== 1)
         $display("FAIL rd0_pulses got %0d want 1", o_done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0)
         $display("FAIL rd0_data got %h/%b want deadbeef/0",
                  o_rdata, o_err);
      else pass_cnt++;
      total_cnt++;
      if (o_addr !== 32'h8000_0004 || o_ar_cyc !== 1)
         $display("FAIL rd0_ar got %h/%0d want 80000004/1",
                  o_addr, o_ar_cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_bad || o_late)
         $display("FAIL rd0_proto got bad=%0d late=%0d want 0/0",
                  o_bad, o_late);
      else pass_cnt++;
   endtask

   task automatic test_read_wait;
      run_txn(0, 32'h8000_0040, 0, 0, 0, 0, 2, 3, 0,
              2'b00, 32'h0BAD_F00D, 2);
      rd_model = 32'h0BAD_F00D;
      total_cnt++;
      if (o_done_cyc !== 8)
         $display("FAIL rdw_latency got %0d want 8", o_done_cyc);
      else pass_cnt++;
      total_cnt++;
      if (o_ar_hs !== 1 || o_ar_cyc !== 3 || o_unstable)
         $display("FAIL rdw_ar got hs=%0d cyc=%0d unst=%0d want 1/3/0",
                  o_ar_hs, o_ar_cyc, o_unstable);
      else pass_cnt++;
      total_cnt++;
      if (o_rdata !== 32'h0BAD_F00D || o_done_cnt !== 1)
         $display("FAIL rdw_data got %h/%0d want 0badf00d/1",
                  o_rdata, o_done_cnt);
      else pass_cnt++;
   endtask

   task automatic test_write_w_first;
      run_txn(1, 32'h8000_0102, 32'h00AB_0000, 4'b0100,
              2, 0, 0, 0, 1, 2'b00, 32'h0, 2);
      total_cnt++;
      if (o_addr !== 32'h8000_0100)
         $display("FAIL wrw_awaddr got %h want 80000100", o_addr);
      else pass_cnt++;
      total_cnt++;
      if (o_wdata !== 32'h00AB_0000 || o_wstrb !== 4'b0100)
         $display("FAIL wrw_wbeat got %h/%b want 00ab0000/0100",
                  o_wdata, o_wstrb);
      else pass_cnt++;
      total_cnt++;
      if (o_w_cyc !== 1 || o_aw_cyc !== 3 || o_late || o_unstable)
         $display("FAIL wrw_order got w=%0d aw=%0d late=%0d want 1/3/0",
                  o_w_cyc, o_aw_cyc, o_late);
      else pass_cnt++;
      total_cnt++;
      if (o_b_hs !== 1 || o_done_cyc !== 6 || o_done_cnt !== 1)
         $display("FAIL wrw_done got b=%0d cyc=%0d n=%0d want 1/6/1",
                  o_b_hs, o_done_cyc, o_done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (o_rdata !== rd_model || o_err !== 1'b0 || o_bad)
         $display("FAIL wrw_hold got %h/%b want %h/0",
                  o_rdata, o_err, rd_model);
      else pass_cnt++;
   endtask

   task automatic test_write_simul;
      run_txn(1, 32'h8000_0200, 32'h1122_3344, 4'b1111,
              0, 0, 0, 0, 0, 2'b00, 32'h0, 2);
      total_cnt++;
      if (o_aw_hs !== 1 || o_w_hs !== 1 || o_b_hs !== 1 || o_late)
         $display("FAIL wrs_beats got aw=%0d w=%0d b=%0d want 1/1/1",
                  o_aw_hs, o_w_hs, o_b_hs);
      else pass_cnt++;
      total_cnt++;
      if (o_done_cyc !== 3 || o_bad)
         $display("FAIL wrs_latency got %0d bad=%0d want 3/0",
                  o_done_cyc, o_bad);
      else pass_cnt++;
   endtask

   task automatic test_errors;
      run_txn(1, 32'h8000_0300, 32'hCAFE_0000, 4'b1100,
              0, 1, 0, 0, 0, 2'b10, 32'h0, 1);
      total_cnt++;
      if (o_err !== 1'b1 || o_done_cyc !== 4)
         $display("FAIL err_bresp got %b/%0d want 1/4", o_err, o_done_cyc);
      else pass_cnt++;
      run_txn(0, 32'h8000_0304, 0, 0, 0, 0, 1, 0, 0,
              2'b11, 32'h5555_AAAA, 1);
      rd_model = 32'h5555_AAAA;
      total_cnt++;
      if (o_err !== 1'b1 || o_rdata !== 32'h5555_AAAA)
         $display("FAIL err_rresp got %b/%h want 1/5555aaaa",
                  o_err, o_rdata);
      else pass_cnt++;
      run_txn(0, 32'h8000_0308, 0, 0, 0, 0, 0, 0, 0,
              2'b00, 32'h7777_0001, 1);
      rd_model = 32'h7777_0001;
      total_cnt++;
      if (o_err !== 1'b0 || o_rdata !== 32'h7777_0001)
         $display("FAIL err_okay got %b/%h want 0/77770001",
                  o_err, o_rdata);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      core_valid = 1; core_wen = 0; core_addr = 32'h8000_0010;
      @(posedge clk); @(negedge clk);
      m_arready = 1;
      @(posedge clk); @(negedge clk);
      m_arready = 0;
      total_cnt++;
      if (m_rready !== 1'b1)
         $display("FAIL rstm_rddata got rready=%b want 1", m_rready);
      else pass_cnt++;
      rst_b = 0;
      #1;
      total_cnt++;
      if ({m_arvalid, m_awvalid, m_wvalid, m_rready,
           m_bready, core_done} !== 6'b0)
         $display("FAIL rstm_async got %b want 000000",
                  {m_arvalid, m_awvalid, m_wvalid, m_rready,
                   m_bready, core_done});
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({m_arvalid, m_rready, core_done} !== 3'b0 ||
          core_rdata !== 32'h0)
         $display("FAIL rstm_hold got %b/%h want 000/0",
                  {m_arvalid, m_rready, core_done}, core_rdata);
      else pass_cnt++;
      rst_b = 1;
      rd_model = 32'h0;
      run_txn(0, 32'h8000_0020, 0, 0, 0, 0, 0, 0, 0,
              2'b00, 32'h1234_5678, 2);
      rd_model = 32'h1234_5678;
      total_cnt++;
      if (o_done_cyc !== 3 || o_ar_hs !== 1 ||
          o_addr !== 32'h8000_0020 || o_rdata !== 32'h1234_5678)
         $display("FAIL rstm_fresh got cyc=%0d hs=%0d a=%h d=%h",
                  o_done_cyc, o_ar_hs, o_addr, o_rdata);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      bit          wen;
      logic [31:0] addr, wd, rd;
      logic [3:0]  st;
      logic [1:0]  resp;
      int          aw_w, w_w, ar_w, r_w, b_w, lat, nerr;
      nerr = 0;
      for (int i = 0; i < 40; i++) begin
         wen  = 1'($urandom_range(0, 1));
         addr = $urandom; wd = $urandom; rd = $urandom;
         st   = 4'($urandom_range(0, 15));
         if (i == 5) st = 4'b0000;
         resp = ($urandom_range(0, 3) == 0) ?
                2'($urandom_range(1, 3)) : 2'b00;
         aw_w = $urandom_range(0, 3); w_w = $urandom_range(0, 3);
         ar_w = $urandom_range(0, 3); r_w = $urandom_range(0, 3);
         b_w  = $urandom_range(0, 3);
         run_txn(wen, addr, wd, st, aw_w, w_w, ar_w, r_w, b_w,
                 resp, rd, (i == 39) ? 2 : 0);
         // After the first, each request is raised during DONE.
         lat = wen ? 3 + ((aw_w > w_w) ? aw_w : w_w) + b_w
                   : 3 + ar_w + r_w;
         if (i > 0) lat++;
         if (!wen) rd_model = rd;
         total_cnt++;
         if (o_done_cyc !== lat || o_done_cnt !== 1)
            $display("FAIL b2b_latency[%0d] got %0d/%0d want %0d/1",
                     i, o_done_cyc, o_done_cnt, lat);
         else pass_cnt++;
         total_cnt++;
         if (o_err !== (resp != 2'b00) || o_rdata !== rd_model)
            $display("FAIL b2b_result[%0d] got %b/%h want %b/%h",
                     i, o_err, o_rdata, resp != 2'b00, rd_model);
         else pass_cnt++;
         total_cnt++;
         if (o_addr !== {addr[31:2], 2'b00})
            $display("FAIL b2b_addr[%0d] got %h want %h",
                     i, o_addr, {addr[31:2], 2'b00});
         else pass_cnt++;
         total_cnt++;
         if (wen && (o_wdata !== wd || o_wstrb !== st ||
                     o_aw_hs !== 1 || o_w_hs !== 1 ||
                     o_b_hs !== 1 || o_ar_hs !== 0))
            $display("FAIL b2b_write[%0d] got %h/%b hs=%0d%0d%0d want %h/%b",
                     i, o_wdata, o_wstrb, o_aw_hs, o_w_hs, o_b_hs, wd, st);
         else if (!wen && (o_ar_hs !== 1 || o_r_hs !== 1 ||
                           o_aw_hs !== 0 || o_w_hs !== 0))
            $display("FAIL b2b_read[%0d] got ar=%0d r=%0d aw=%0d w=%0d",
                     i, o_ar_hs, o_r_hs, o_aw_hs, o_w_hs);
         else pass_cnt++;
         if (o_late || o_unstable || o_bad) nerr++;
      end
      total_cnt++;
      if (nerr !== 0)
         $display("FAIL b2b_protocol got %0d violations want 0", nerr);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0; rd_model = '0;
      rst_b = 0; core_valid = 0; core_wen = 0; core_addr = '0;
      core_wstrb = '0; core_wdata = '0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
      m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst_b = 1;
      @(negedge clk);
      test_read_zero();
      test_read_wait();
      test_write_w_first();
      test_write_simul();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lsu_axil_bridge.md
Name: lsu_axil_bridge

Overview:
- Data-memory port bridge that sits directly downstream of the single-cycle core's data-request interface (valid/wen/addr/wstrb/wdata/rdata).
- Converts each core request into one AXI4-Lite master transaction: read uses AR then R; write uses AW and W, then B.
- Returns read data and a one-cycle completion pulse, which the core uses as its stall/advance condition.
- Lets the core run against real multi-cycle memory instead of the simulation-only zero-latency memory model.

Parameters:
- XLEN, 32, data and address width.
- ALIGN_ADDR, 1, when 1 force AXADDR[1:0]=2'b00 (word-aligned bus address); when 0 pass core_addr through unchanged.

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- core_valid  input  1  data request; held stable with all core_* fields until core_done
- core_wen  input  1  1=write, 0=read
- core_addr  input  XLEN  byte address
- core_wstrb  input  4  byte write strobe
- core_wdata  input  XLEN  write data, already lane-aligned
- core_done  output  1  one-cycle completion pulse
- core_rdata  output  XLEN  read data, valid when core_done && !core_wen
- core_err  output  1  bus error, valid with core_done
- m_awvalid  output  1  AW channel valid
- m_awready  input  1  AW channel ready
- m_awaddr  output  XLEN  AW channel address
- m_wvalid  output  1  W channel valid
- m_wready  input  1  W channel ready
- m_wdata  output  XLEN  W channel data
- m_wstrb  output  4  W channel byte strobe
- m_bvalid  input  1  B channel valid
- m_bready  output  1  B channel ready
- m_bresp  input  2  B channel response
- m_arvalid  output  1  AR channel valid
- m_arready  input  1  AR channel ready
- m_araddr  output  XLEN  AR channel address
- m_rvalid  input  1  R channel valid
- m_rready  output  1  R channel ready
- m_rdata  input  XLEN  R channel data
- m_rresp  input  2  R channel response

Behaviour:
- Clock and reset: single clock clk. Reset rst_b is asynchronous, active-low.
- Reset values: state=IDLE. All m_*valid, m_*ready, core_done and core_err are 0. core_rdata=0. Address and data registers are 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - On core_valid, register addr, wdata, wstrb and wen.
  - If wen, go to WR_REQ. Otherwise go to RD_ADDR.
- RD_ADDR:
  - m_arvalid=1 from a register; m_araddr is the registered address.
  - On m_arready, drop m_arvalid and go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On m_rvalid, capture m_rdata into core_rdata, set err_q=(m_rresp!=2'b00), go to DONE.
- WR_REQ:
  - m_awvalid and m_wvalid are both 1 on entry. Each is tracked by its own "sent" flag.
  - Each valid drops independently on its own ready.
  - AW and W may complete in the same cycle or in either order.
  - When both are sent (including both in one cycle), go to WR_RESP.
- WR_RESP:
  - m_bready=1.
  - On m_bvalid, set err_q=(m_bresp!=2'b00), go to DONE. core_rdata is left unchanged.
- DONE:
  - core_done=1 and core_err=err_q for exactly one cycle, then go to IDLE.
  - core_valid is ignored in DONE.
  - A core_valid seen in IDLE after DONE is treated as a new request, allowing back-to-back requests.
- Latency:
  - With zero-wait slaves (ready/valid returned the cycle after the request is presented), core_done asserts 3 cycles after core_valid is first sampled in IDLE, for both read and write.
  - Each slave wait cycle adds 1 cycle.
- Address and data:
  - m_awaddr = m_araddr = registered address, with [1:0] cleared when ALIGN_ADDR=1.
  - m_wdata and m_wstrb are the registered values.
  - A write with wstrb=0 is still issued on the bus.
- AXI rules:
  - Once asserted, a valid stays high with stable payload until its handshake.
  - There is never more than one outstanding transaction.
  - m_rready and m_bready are asserted only in their own states.
- Reset mid-transaction: everything returns to reset values immediately, including deasserting any valid. The slave must be reset by the same rst_b. No core_done is produced for the aborted request.
- core_rdata holds its last captured value until the next read completes.

Test Plan:
- Read with zero-wait slave:
  - Stimulus: core_valid=1, wen=0, addr=0x80000004. Slave returns rdata=0xDEADBEEF, rresp=0.
  - Required: m_arvalid high for 1 cycle with araddr=0x80000004; core_done pulses exactly once, 3 cycles after request; core_rdata=0xDEADBEEF; core_err=0.
- Read with waits:
  - Stimulus: arready delayed 2 cycles, rvalid delayed 3 cycles.
  - Required: araddr stable while m_arvalid high; done at cycle 8; exactly one AR handshake.
- Write, W before AW:
  - Stimulus: addr=0x80000102, wdata=0x00AB0000, wstrb=4'b0100, ALIGN_ADDR=1. wready at cycle 1, awready at cycle 3.
  - Required: awaddr=0x80000100; m_wvalid drops after cycle 1 while m_awvalid remains high until its handshake; single B handshake; done 1 cycle after bvalid.
- Write with simultaneous AW/W ready:
  - Stimulus: AW and W ready in the same cycle.
  - Required: transition to WR_RESP; no duplicate beats.
- Error responses:
  - Stimulus: bresp=2'b10 on a write, then rresp=2'b11 on the next read.
  - Required: core_err=1 with each done pulse; core_err=0 on a following OKAY transaction.
- Reset mid-read:
  - Stimulus: rst_b low while in RD_DATA; core_valid held high; rst_b released.
  - Required: all valids 0 and core_done=0 during reset; a fresh AR is issued after reset release.
